// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter over raster-order frames.
// Produces one registered output per interior pixel, as a saturated magnitude or a thresholded binary value.
module sobel_stream #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int PIX_W  = 8,
    parameter int MODE   = 0,
    parameter int THRESH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = PIX_W + 3;
    localparam int MW = PIX_W + 4;
    localparam logic [PIX_W-1:0] MAXPIX = '1;

    logic [CW-1:0]    colCnt_q, colCnt_d;
    logic [RW-1:0]    rowCnt_q, rowCnt_d;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];
    logic [PIX_W-1:0] winShift [9];
    logic             outValid_q, outValid_d;
    logic [PIX_W-1:0] outPix_q, outPix_d;
    logic             outLast_q, outLast_d;

    // lineBufNear holds row-1, lineBufFar holds row-2, both indexed by column
    logic [PIX_W-1:0] lineBufNear [IMG_W];
    logic [PIX_W-1:0] lineBufFar  [IMG_W];
    logic [PIX_W-1:0] aboveOne, aboveTwo;

    logic              accept, genOut, lastOut;
    logic signed [GW-1:0] gradX, gradY;
    logic [GW-1:0]     absX, absY;
    logic [MW-1:0]     magnitude;
    logic [PIX_W-1:0]  resultPix;

    function automatic logic signed [GW-1:0] zext(input logic [PIX_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    assign in_ready  = !outValid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = outValid_q;
    assign out_pixel = outPix_q;
    assign out_last  = outLast_q;

    assign aboveOne = lineBufNear[colCnt_q];
    assign aboveTwo = lineBufFar[colCnt_q];

    // Line buffers carry no reset; stale rows never reach an output because row < 2 is never emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lineBufFar[colCnt_q]  <= lineBufNear[colCnt_q];
            lineBufNear[colCnt_q] <= in_pixel;
        end
    end

    always_comb begin
        colCnt_d = colCnt_q;
        rowCnt_d = rowCnt_q;
        if (accept) begin
            if (colCnt_q == CW'(IMG_W - 1)) begin
                colCnt_d = '0;
                rowCnt_d = (rowCnt_q == RW'(IMG_H - 1)) ? '0 : rowCnt_q + RW'(1);
            end else begin
                colCnt_d = colCnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        winShift[0] = win_q[1];
        winShift[1] = win_q[2];
        winShift[2] = aboveTwo;
        winShift[3] = win_q[4];
        winShift[4] = win_q[5];
        winShift[5] = aboveOne;
        winShift[6] = win_q[7];
        winShift[7] = win_q[8];
        winShift[8] = in_pixel;
        for (int i = 0; i < 9; i++) begin
            win_d[i] = accept ? winShift[i] : win_q[i];
        end
    end

    // Filter operates on the shifted window so the result is ready on the accepting edge.
    always_comb begin
        gradX = (zext(winShift[2]) + (zext(winShift[5]) <<< 1) + zext(winShift[8]))
              - (zext(winShift[0]) + (zext(winShift[3]) <<< 1) + zext(winShift[6]));
        gradY = (zext(winShift[6]) + (zext(winShift[7]) <<< 1) + zext(winShift[8]))
              - (zext(winShift[0]) + (zext(winShift[1]) <<< 1) + zext(winShift[2]));
        absX = gradX[GW-1] ? GW'(-gradX) : GW'(gradX);
        absY = gradY[GW-1] ? GW'(-gradY) : GW'(gradY);
        magnitude = MW'(absX) + MW'(absY);
        if (MODE == 1) begin
            resultPix = (magnitude >= MW'(THRESH)) ? MAXPIX : '0;
        end else begin
            resultPix = (magnitude > MW'(MAXPIX)) ? MAXPIX : magnitude[PIX_W-1:0];
        end
    end

    assign genOut  = accept && (rowCnt_q >= RW'(2)) && (colCnt_q >= CW'(2));
    assign lastOut = (rowCnt_q == RW'(IMG_H - 1)) && (colCnt_q == CW'(IMG_W - 1));

    always_comb begin
        outValid_d = outValid_q;
        outPix_d   = outPix_q;
        outLast_d  = outLast_q;
        if (genOut) begin
            outValid_d = 1'b1;
            outPix_d   = resultPix;
            outLast_d  = lastOut;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colCnt_q   <= '0;
            rowCnt_q   <= '0;
            outValid_q <= 1'b0;
            outPix_q   <= '0;
            outLast_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            colCnt_q   <= colCnt_d;
            rowCnt_q   <= rowCnt_d;
            outValid_q <= outValid_d;
            outPix_q   <= outPix_d;
            outLast_q  <= outLast_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter IMG_W, default 64, pixels per image row (SHALL be >= 3).
REQ-002 Parameter IMG_H, default 64, rows per frame (SHALL be >= 3).
REQ-003 Parameter PIX_W, default 8, pixel bit width (input and output).
REQ-004 Parameter MODE, default 0: 0 = saturated gradient magnitude out, 1 = binary threshold out.
REQ-005 Parameter THRESH, default 128, threshold used when MODE=1.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 in_valid  input  1  in_pixel holds a valid pixel.
REQ-009 in_ready  output  1  block accepts a pixel this cycle.
REQ-010 in_pixel  input  PIX_W  unsigned pixel, raster order (row-major, row 0 col 0 first).
REQ-011 out_valid  output  1  out_pixel/out_last valid.
REQ-012 out_ready  input  1  downstream accepts output this cycle.
REQ-013 out_pixel  output  PIX_W  filtered interior pixel.
REQ-014 out_last  output  1  marks last output pixel of a frame.

Function
REQ-015 Input transfer occurs on a posedge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-016 in_ready SHALL equal (!out_valid || out_ready); combinational, no other stall source.
REQ-017 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on input transfer; col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame begins, no idle cycle).
REQ-018 Two line buffers of IMG_W x PIX_W SHALL hold the previous two rows; a 3x3 window register SHALL shift by one column per input transfer.
REQ-019 Window P0..P8 row-major: P0..P2 from row-2, P3..P5 from row-1, P6..P8 from current row; P8 = pixel just accepted.
REQ-020 Only interior centres (1..IMG_H-2, 1..IMG_W-2) SHALL produce output: an output is generated when the accepted pixel has row >= 2 and col >= 2; centre = (row-1, col-1).
REQ-021 Output count per frame SHALL be exactly (IMG_W-2)*(IMG_H-2); no border pixels, no padding.
REQ-022 Gx = (P2+2*P5+P8) - (P0+2*P3+P6); Gy = (P6+2*P7+P8) - (P0+2*P1+P2); signed, PIX_W+3 bits, no overflow.
REQ-023 mag = |Gx| + |Gy| in PIX_W+4 bits; MODE=0: out_pixel = min(mag, 2^PIX_W-1).
REQ-024 MODE=1: out_pixel = all ones if mag >= THRESH else 0.
REQ-025 Latency: out_valid SHALL assert on the posedge that accepts the generating input pixel (registered output, one stage); out_valid clears on output transfer unless a new output is loaded same cycle.
REQ-026 Simultaneous output transfer and new generating input: out register reloads, out_valid stays 1, no bubble.
REQ-027 While out_valid && !out_ready: out_pixel, out_last SHALL hold stable and no input SHALL be accepted.
REQ-028 out_last SHALL be 1 exactly for centre (IMG_H-2, IMG_W-2), else 0.
REQ-029 Line-buffer contents from the previous frame SHALL NOT affect outputs (guaranteed by REQ-020).

Reset
REQ-030 On rst high, asynchronously: out_valid=0, out_pixel=0, out_last=0, col=0, row=0, window cleared; in_ready therefore 1.
REQ-031 Line-buffer RAM need not be cleared.
REQ-032 Reset mid-frame SHALL discard the partial frame; first pixel after rst release is row 0 col 0.

Verification
REQ-033 Defaults, constant frame of 100, out_ready=1 -> 3844 outputs all 0, out_last only on 3844th.
REQ-034 Defaults, cols 0..31 = 0, cols 32..63 = 200 -> centres at col 31 and 32 = 255 (Gx=800 saturated), all others 0.
REQ-035 Same stimulus, out_ready held low 10 cycles mid-frame -> in_ready low, out_pixel stable, output sequence identical to REQ-034.
REQ-036 MODE=1, THRESH=128, step 0->40 at col 32 (mag=160) -> cols 31,32 = 255; step 0->20 (mag=80) -> all 0.
REQ-037 IMG_W=5, IMG_H=4, pixel value = row*5+col -> 6 outputs, each Gx=8, Gy=40, out_pixel=48.
REQ-038 rst asserted after 1000 input pixels, then full REQ-034 frame -> out_valid=0 during reset, exactly 3844 correct outputs afterwards.
